instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the CPU core. Takes the CPU's 8-bit PC (rom_address) and reads the two instruction bytes from a byte-wide program ROM over a req/ack handshake with variable latency. It holds the assembled opcode1/opcode2 pair stable with instr_valid until the core consumes it. Jumps are absorbed by refetching whenever the PC changes under an outstanding or held fetch.

---
 rtl/instr_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetches the two-byte instruction at pc_addr from a byte-wide ROM and holds it for the core.
// Latency: zero-wait ROM gives instr_valid 3 cycles after the IDLE sample cycle (+1 per ROM wait state).
// Backpressure: opcode pair held with instr_valid until instr_taken; ROM stalls via rom_rd_ack.
// Optional: define IFU_ALIGN_CHECK_EN to trap odd PCs as fetch errors instead of fetching them.
module instr_fetch_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc_addr,
  output logic [7:0] rom_rd_addr,
  output logic       rom_rd_req,
  input  logic       rom_rd_ack,
  input  logic [7:0] rom_rd_data,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic       instr_valid,
  input  logic       instr_taken,
  output logic       fetch_busy,
  output logic       fetch_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ_B0 = 3'd1;
  localparam logic [2:0] REQ_B1 = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  // Last counter value before the timeout fires; the counter tracks stalled cycles already seen.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] addr_a;
  logic [7:0] to_cnt;
  logic       pc_moved;
  logic       pc_diff;
  logic       ack_seen;
  logic       discard;
  logic       in_req;
  logic       entering_req;

  assign pc_diff      = (pc_addr != addr_a);
  // An ack only counts while our own request is on the bus.
  assign ack_seen     = rom_rd_ack & rom_rd_req;
  // A PC change at any point of the handshake (including the ack cycle) makes this byte stale.
  assign discard      = pc_moved | pc_diff;
  assign in_req       = (state == REQ_B0) || (state == REQ_B1);
  assign entering_req = (state_nxt != state) && ((state_nxt == REQ_B0) || (state_nxt == REQ_B1));
  assign fetch_busy   = in_req;

  // Next-state decision for the fetch sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef IFU_ALIGN_CHECK_EN
        if (pc_addr[0]) begin
          state_nxt = ERR;
        end else begin
          state_nxt = REQ_B0;
        end
`else
        state_nxt = REQ_B0;
`endif
      end
      REQ_B0: begin
        if (ack_seen) begin
          state_nxt = discard ? IDLE : REQ_B1;
        end else if (to_cnt == TIMEOUT_LAST) begin
          state_nxt = ERR;
        end
      end
      REQ_B1: begin
        if (ack_seen) begin
          state_nxt = discard ? IDLE : HOLD;
        end else if (to_cnt == TIMEOUT_LAST) begin
          state_nxt = ERR;
        end
      end
      HOLD: begin
        // instr_taken and a PC change both lead back to IDLE, so taken needs no priority logic.
        if ((instr_valid && instr_taken) || pc_diff) begin
          state_nxt = IDLE;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; ERR is absorbing and only reset leaves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the PC of the instruction being fetched while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_a <= 8'h00;
    end else if (state == IDLE) begin
      addr_a <= pc_addr;
    end
  end

  // Registered ROM request; address only moves when a new byte handshake starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_rd_req  <= 1'b0;
      rom_rd_addr <= 8'h00;
    end else begin
      rom_rd_req <= (state_nxt == REQ_B0) || (state_nxt == REQ_B1);
      if ((state == IDLE) && (state_nxt == REQ_B0)) begin
        rom_rd_addr <= pc_addr;
      end else if ((state == REQ_B0) && (state_nxt == REQ_B1)) begin
        rom_rd_addr <= addr_a + 8'd1;
      end
    end
  end

  // Count stalled request cycles, restarting for every byte handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= 8'h00;
    end else if (entering_req) begin
      to_cnt <= 8'h00;
    end else if (in_req && rom_rd_req && !rom_rd_ack) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Remember a PC change seen while a handshake is in flight; that fetch is abandoned after its ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_moved <= 1'b0;
    end else if (state == IDLE) begin
      pc_moved <= 1'b0;
    end else if (in_req && pc_diff) begin
      pc_moved <= 1'b1;
    end
  end

  // Capture instruction bytes on ack unless the fetch has gone stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode1 <= 8'h00;
      opcode2 <= 8'h00;
    end else begin
      if ((state == REQ_B0) && ack_seen && !discard) begin
        opcode1 <= rom_rd_data;
      end
      if ((state == REQ_B1) && ack_seen && !discard) begin
        opcode2 <= rom_rd_data;
      end
    end
  end

  // Valid and error flags are registered decodes of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      instr_valid <= (state_nxt == HOLD);
      fetch_err   <= (state_nxt == ERR);
    end
  end

  a_busy_has_req: assert property (@(posedge clk) disable iff (reset) fetch_busy |-> rom_rd_req);
  a_valid_no_req: assert property (@(posedge clk) disable iff (reset) instr_valid |-> !rom_rd_req);
  a_err_sticky:   assert property (@(posedge clk) disable iff (reset) fetch_err |=> fetch_err);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc_addr;
  logic [7:0] rom_rd_addr;
  logic       rom_rd_req;
  logic       rom_rd_ack;
  logic [7:0] rom_rd_data;
  logic [7:0] opcode1;
  logic [7:0] opcode2;
  logic       instr_valid;
  logic       instr_taken;
  logic       fetch_busy;
  logic       fetch_err;

  logic [7:0] rom [256];
  int n_cmp = 0;
  int n_err = 0;

  // ROM responder controls
  bit ack_en      = 1'b1;
  bit rand_waits  = 1'b0;
  bit junk_en     = 1'b0;
  int fixed_waits = 0;

  instr_fetch_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr),
    .rom_rd_addr(rom_rd_addr), .rom_rd_req(rom_rd_req),
    .rom_rd_ack(rom_rd_ack), .rom_rd_data(rom_rd_data),
    .opcode1(opcode1), .opcode2(opcode2), .instr_valid(instr_valid),
    .instr_taken(instr_taken), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural ROM: each new request waits a number of cycles, then acks with rom[addr].
  initial begin
    bit         rsp_active;
    logic [7:0] rsp_addr;
    int         rsp_cnt;
    int         rsp_wait;
    rsp_active = 1'b0; rsp_addr = 8'h00; rsp_cnt = 0; rsp_wait = 0;
    rom_rd_ack = 1'b0; rom_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rom_rd_req) begin
        rsp_active = 1'b0;
        rom_rd_ack = junk_en;
        rom_rd_data = 8'($urandom);
      end else begin
        if (!rsp_active || rom_rd_addr != rsp_addr) begin
          rsp_active = 1'b1;
          rsp_addr = rom_rd_addr;
          rsp_cnt = 0;
          rsp_wait = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
        end
        if (ack_en && rsp_cnt == rsp_wait) begin
          rom_rd_ack = 1'b1;
          rom_rd_data = rom[rsp_addr];
        end else begin
          rom_rd_ack = 1'b0;
          rom_rd_data = 8'($urandom);
        end
        rsp_cnt++;
      end
    end
  end

  function automatic logic [7:0] rand_pc();
`ifdef IFU_ALIGN_CHECK_EN
    return 8'($urandom) & 8'hFE;
`else
    return 8'($urandom);
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    instr_taken = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // From the IDLE sample cycle (cycle 0), expect req for 2w+2 cycles and valid at cycle 2w+3.
  task automatic run_timeline(input logic [7:0] a, input int w, input string tag);
    logic [7:0] a1;
    int last;
    a1 = a + 8'd1;
    last = 2 * w + 3;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (rom_rd_req !== (k < last) || fetch_busy !== (k < last) || instr_valid !== (k == last)) begin
        n_err++;
        $display("FAIL %s cycle %0d ctl: req=%b busy=%b valid=%b required req=%b busy=%b valid=%b",
                 tag, k, rom_rd_req, fetch_busy, instr_valid, (k < last), (k < last), (k == last));
      end
      if (k < last) begin
        n_cmp++;
        if (rom_rd_addr !== ((k <= w + 1) ? a : a1)) begin
          n_err++;
          $display("FAIL %s cycle %0d addr: got %h required %h", tag, k, rom_rd_addr,
                   ((k <= w + 1) ? a : a1));
        end
      end
    end
    n_cmp++;
    if (opcode1 !== rom[a] || opcode2 !== rom[a1]) begin
      n_err++;
      $display("FAIL %s opcodes: got %h/%h required %h/%h", tag, opcode1, opcode2, rom[a], rom[a1]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rom_rd_addr, rom_rd_req, opcode1, opcode2, instr_valid, fetch_busy, fetch_err} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_values: addr=%h req=%b op=%h/%h valid=%b busy=%b err=%b required all 0",
               rom_rd_addr, rom_rd_req, opcode1, opcode2, instr_valid, fetch_busy, fetch_err);
    end
  endtask

  task automatic test_zero_wait();
    pc_addr = 8'h00; fixed_waits = 0; rand_waits = 1'b0;
    do_reset();
    n_cmp++;
    if (rom_rd_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_wait cycle0: req=%b valid=%b required 0/0", rom_rd_req, instr_valid);
    end
    run_timeline(8'h00, 0, "zero_wait");
  endtask

  task automatic test_wait_states();
    pc_addr = 8'h10; fixed_waits = 3;
    do_reset();
    run_timeline(8'h10, 3, "wait3");
  endtask

  task automatic test_taken();
    // Still holding the 0x10 pair here.
    instr_taken = 1'b1;
    pc_addr = 8'h12;
    @(posedge clk); @(negedge clk);
    instr_taken = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || rom_rd_req !== 1'b0 || fetch_busy !== 1'b0) begin
      n_err++;
      $display("FAIL taken_idle: valid=%b req=%b busy=%b required 0/0/0", instr_valid, rom_rd_req, fetch_busy);
    end
    fixed_waits = 1;
    run_timeline(8'h12, 1, "taken_refetch");
  endtask

  task automatic test_jump();
    pc_addr = 8'h10; fixed_waits = 2;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (instr_valid !== 1'b0 || rom_rd_req !== (k < 7) ||
          (k < 7 && rom_rd_addr !== ((k <= 3) ? 8'h10 : 8'h11))) begin
        n_err++;
        $display("FAIL jump cycle %0d: valid=%b req=%b addr=%h required valid=0 req=%b addr=%h",
                 k, instr_valid, rom_rd_req, rom_rd_addr, (k < 7), ((k <= 3) ? 8'h10 : 8'h11));
      end
      if (k == 4) pc_addr = 8'h40;
    end
    run_timeline(8'h40, 2, "jump_refetch");
  endtask

  task automatic test_wrap();
    pc_addr = 8'hFF; fixed_waits = 1;
    do_reset();
`ifdef IFU_ALIGN_CHECK_EN
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (rom_rd_req !== 1'b0 || fetch_err !== 1'b1 || fetch_busy !== 1'b0 || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL align cycle %0d: req=%b err=%b busy=%b valid=%b required 0/1/0/0",
                 k, rom_rd_req, fetch_err, fetch_busy, instr_valid);
      end
    end
`else
    run_timeline(8'hFF, 1, "wrap_ff");
`endif
  endtask

  task automatic test_timeout();
    ack_en = 1'b0; junk_en = 1'b0;
    pc_addr = 8'h20;
    do_reset();
    for (int k = 1; k <= TO + 5; k++) begin
      if (k == TO + 2) begin
        ack_en = 1'b1; junk_en = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (rom_rd_req !== (k <= TO) || fetch_busy !== (k <= TO) || fetch_err !== (k > TO) ||
          instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL timeout cycle %0d: req=%b busy=%b err=%b valid=%b required req=%b busy=%b err=%b valid=0",
                 k, rom_rd_req, fetch_busy, fetch_err, instr_valid, (k <= TO), (k <= TO), (k > TO));
      end
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({rom_rd_addr, rom_rd_req, opcode1, opcode2, instr_valid, fetch_busy, fetch_err} !== 27'd0) begin
      n_err++;
      $display("FAIL timeout_reset: addr=%h req=%b op=%h/%h valid=%b busy=%b err=%b required all 0",
               rom_rd_addr, rom_rd_req, opcode1, opcode2, instr_valid, fetch_busy, fetch_err);
    end
    junk_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    pc_addr = 8'h30; fixed_waits = 3; junk_en = 1'b0;
    do_reset();
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (rom_rd_req !== 1'b0 || fetch_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: req=%b busy=%b required 0/0", rom_rd_req, fetch_busy);
    end
    // Spurious acks while req is low must not corrupt the next fetch.
    junk_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    run_timeline(8'h30, 3, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] e1, e2, pc1;
    bit got;
    rand_waits = 1'b1; junk_en = 1'b1; ack_en = 1'b1;
    pc_addr = rand_pc();
    do_reset();
    for (int it = 0; it < 40; it++) begin
      got = 1'b0;
      for (int b = 0; b < 200; b++) begin
        @(negedge clk);
        if (instr_valid) begin
          got = 1'b1;
          break;
        end
        if ($urandom_range(0, 7) == 0) pc_addr = rand_pc();
      end
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL random iter %0d: instr_valid=0 after 200 cycles required 1", it);
        break;
      end
      pc1 = pc_addr + 8'd1;
      e1 = rom[pc_addr];
      e2 = rom[pc1];
      n_cmp++;
      if (opcode1 !== e1 || opcode2 !== e2 || rom_rd_req !== 1'b0 || fetch_busy !== 1'b0 || fetch_err !== 1'b0) begin
        n_err++;
        $display("FAIL random iter %0d pc=%h: op=%h/%h req=%b busy=%b err=%b required op=%h/%h 0/0/0",
                 it, pc_addr, opcode1, opcode2, rom_rd_req, fetch_busy, fetch_err, e1, e2);
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b1 || opcode1 !== e1 || opcode2 !== e2) begin
          n_err++;
          $display("FAIL random hold iter %0d: valid=%b op=%h/%h required 1 %h/%h",
                   it, instr_valid, opcode1, opcode2, e1, e2);
        end
      end
      case ($urandom_range(0, 2))
        0: begin instr_taken = 1'b1; pc_addr = rand_pc(); end
        1: pc_addr = pc_addr + 8'd2;
        default: instr_taken = 1'b1;
      endcase
      @(negedge clk);
      instr_taken = 1'b0;
      n_cmp++;
      if (instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL random release iter %0d: valid=%b required 0", it, instr_valid);
      end
    end
    rand_waits = 1'b0; junk_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pc_addr = 8'h00;
    instr_taken = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h1A;
    rom[1] = 8'h05;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_taken();
    test_jump();
    test_wrap();
    test_mid_reset();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
